// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // RV32I funct3 encodings for loads
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // RV32I funct3 encodings for stores
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Response error codes as seen on resp_err
    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_ILLEGAL    = 2'd3
    } lsu_err_t;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store byte enables and data replication, and
// load lane shift with sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              st_write,
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_lane,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [XLEN/8-1:0] st_be,
    output logic [XLEN-1:0]   st_wdata_rep,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_lane,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [XLEN-1:0] byte_rep;
    logic [XLEN-1:0] half_rep;
    logic [XLEN-1:0] shifted;

    // Every byte lane carries the low byte; alternate lanes carry the low halfword
    generate
        for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
            assign byte_rep[gi*8 +: 8] = st_wdata[7:0];
            assign half_rep[gi*8 +: 8] = st_wdata[(gi%2)*8 +: 8];
        end
    endgenerate

    // Store byte enables and replicated write data; loads read the whole word
    always_comb begin
        st_be        = '1;
        st_wdata_rep = '0;
        if (st_write) begin
            case (st_funct3)
                SB: begin
                    st_be        = {{(XLEN/8-1){1'b0}}, 1'b1} << st_lane;
                    st_wdata_rep = byte_rep;
                end
                SH: begin
                    st_be        = {{(XLEN/8-2){1'b0}}, 2'b11} << st_lane;
                    st_wdata_rep = half_rep;
                end
                default: begin
                    st_be        = '1;
                    st_wdata_rep = st_wdata;
                end
            endcase
        end
    end

    assign shifted = ld_rdata >> {ld_lane, 3'b000};

    // Extend the addressed byte/halfword of the read word
    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            LB:      ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LBU:     ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LH:      ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LHU:     ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            LW:      ld_data = shifted;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, validates it, runs the memory
// handshake with a timeout, and returns a single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack
);

    lsu_state_t        state_reg;
    logic [7:0]        count_reg;
    logic              write_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        lane_reg;
    logic              resp_valid_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    lsu_err_t          resp_err_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [XLEN/8-1:0] mem_be_reg;
    logic [XLEN-1:0]   mem_wdata_reg;

    logic              illegal;
    logic              misaligned;
    logic [XLEN/8-1:0] st_be;
    logic [XLEN-1:0]   st_wdata_rep;
    logic [XLEN-1:0]   ld_data;

    assign req_ready  = (state_reg == IDLE) & ~rst;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;

    // Store lanes come from the incoming request; load extension uses the latched lane/funct3
    lsu_align #(.XLEN(XLEN)) u_align (
        .st_write     (req_write),
        .st_funct3    (req_funct3),
        .st_lane      (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .ld_funct3    (funct3_reg),
        .ld_lane      (lane_reg),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    // Request validation on the incoming request; illegal outranks misaligned
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_write)
            illegal = (req_funct3 > 3'd2);
        else
            illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        if (req_addr[XLEN-1:ADDR_W+2] != '0)
            illegal = 1'b1;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Access sequencer with request latch, timeout counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            write_reg      <= 1'b0;
            funct3_reg     <= '0;
            lane_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= ERR_OK;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    resp_valid_reg <= 1'b0;
                    if (req_valid) begin
                        write_reg  <= req_write;
                        funct3_reg <= req_funct3;
                        lane_reg   <= req_addr[1:0];
                        if (illegal) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= ERR_ILLEGAL;
                            resp_rdata_reg <= '0;
                        end else if (misaligned) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= ERR_MISALIGNED;
                            resp_rdata_reg <= '0;
                        end else begin
                            state_reg     <= ACCESS;
                            count_reg     <= '0;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_write;
                            mem_addr_reg  <= req_addr[ADDR_W+1:2];
                            mem_be_reg    <= st_be;
                            mem_wdata_reg <= st_wdata_rep;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state_reg      <= RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= ERR_OK;
                        resp_rdata_reg <= write_reg ? '0 : ld_data;
                    end else if (count_reg == 8'(TIMEOUT - 1)) begin
                        state_reg      <= RESP;
                        mem_req_reg    <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= ERR_TIMEOUT;
                        resp_rdata_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= ERR_OK;
                    resp_rdata_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised memory-access engine between the multicycle RV32 control FSM and data memory.
- Handles RV32I loads LB/LH/LW/LBU/LHU and stores SB/SH/SW, with byte-lane alignment, sign/zero extension and byte enables.
- Uses a valid/ready request and an ack-based memory handshake with wait states, timeout, and misalignment and illegal-access reporting.
- The CPU issues one request, then waits for the resp_valid pulse before writeback and PC increment.

Parameters:
- XLEN, 32, data and byte-address width (fixed 32 for RV32; the lane logic assumes XLEN/8 = 4)
- ADDR_W, 10, memory word-address width
- TIMEOUT, 15, maximum cycles in ACCESS without mem_ack before an error (range 1..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  instruction funct3
- req_addr  in  XLEN  byte address (ALU result)
- req_wdata  in  XLEN  rs2 data for stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data (0 for stores and errors)
- resp_err  out  2  0 OK, 1 misaligned, 2 timeout, 3 illegal
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word address, equal to req_addr[ADDR_W+1:2]
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_rdata  in  XLEN  read word
- mem_ack  in  1  memory done; read data valid in the same cycle

Behaviour:
- Reset:
  - state goes to IDLE; all registered outputs go to 0; timeout counter goes to 0.
  - req_ready = (state==IDLE) & !rst.
  - Reset mid-operation abandons the access: mem_req is 0 after the edge and no resp_valid is produced.
- Synchronous active-high reset, as decided: rst is sampled on the rising edge of clk only.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - Acceptance is req_valid & req_ready at edge T. At T, latch write, funct3, addr, wdata and lane = addr[1:0].
  - Checks are applied at acceptance, in priority order:
    - Illegal: load funct3 in {3,6,7}, store funct3 > 2, or addr[XLEN-1:ADDR_W+2] != 0. Result: err 3, go to RESP.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Result: err 1, go to RESP.
    - Otherwise go to ACCESS, with the counter cleared.
  - Errored requests never assert mem_req.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are stable for the whole state.
  - Counter increments each cycle without ack.
  - mem_ack causes a transition to RESP; load data is captured from mem_rdata in that cycle.
  - If counter == TIMEOUT-1 with no ack, go to RESP with err 2, and mem_req drops the next cycle.
  - If ack and timeout coincide, the ack wins (err 0).
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata and resp_err valid in the same cycle; then IDLE.
  - There is no backpressure on the response.
- Latency: acceptance at T, mem_req high from T+1. Ack at T+1 gives resp_valid at T+2. An error gives resp_valid at T+1.
- mem_ack outside ACCESS is ignored.
- Store lanes:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 4'b0001<<lane.
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = 4'b0011<<lane.
  - SW: mem_wdata = wdata, mem_be = 4'b1111.
- Loads: mem_we=0 and mem_be=4'b1111. Data is shifted = mem_rdata >> (8*lane), then:
  - LB: sign-extend [7:0]
  - LBU: zero-extend [7:0]
  - LH: sign-extend [15:0]
  - LHU: zero-extend [15:0]
  - LW: full word
- resp_rdata is 0 for stores and for every err != 0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2
  - lsu_err_t enum {OK, MISALIGNED, TIMEOUT, ILLEGAL}
  - lsu_state_t enum {IDLE, ACCESS, RESP}
- Opcode defines stay in the existing defines file.
- One combinational sub-module, lsu_align: it computes byte enables and wdata replication for stores, and the load lane shift plus extension.
- load_store_unit holds the FSM, the request latch and the timeout counter.

Test Plan:
- LB at addr 0x00000006, mem_rdata 0x12_80_34_56, ack on the first ACCESS cycle -> mem_addr 1, mem_be 4'b1111, resp_rdata 0xFFFFFF80, err 0, resp_valid at T+2.
- LHU at 0x0000000A, mem_rdata 0x8001_0000 -> resp_rdata 0x00008001; same access as LH -> resp_rdata 0xFFFF8001.
- SB at 0x00000003 with wdata 0xAABBCCDD -> mem_we 1, mem_be 4'b1000, mem_wdata 0xDDDDDDDD; SH at 0x00000002 -> mem_be 4'b1100, mem_wdata 0xCCDDCCDD.
- LW at 0x00000002 -> err 1 at T+1, mem_req never high; SW at 0x00001000 (ADDR_W=10) -> err 3; load with funct3=3 -> err 3.
- LW with mem_ack held low, TIMEOUT=15 -> mem_req high for 15 cycles, resp_err 2, resp_rdata 0; ack on the 15th cycle instead -> err 0.
- rst asserted on the 3rd ACCESS cycle -> mem_req 0 and req_ready 0 during rst, no resp_valid, req_ready 1 the cycle after rst deasserts; next LW completes normally.
